// File: rtl/fetch_pkg.sv
// Constants and state encoding shared by the fetch stage and the decoder.
package fetch_pkg;

    localparam int BYTE_W    = 8;
    localparam int INSTR_W   = 4 * BYTE_W;
    localparam int REQ_BYTES = 4;
    localparam int CNT_W     = $clog2(REQ_BYTES);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        DRAIN,
        ISSUE,
        WAIT
    } state_t;

endpackage

// File: rtl/fetch_assembler.sv
// Big-endian instruction assembly buffer: a returned byte lands at the slot chosen
// by the byte index of the read that produced it, one cycle after that read.
module fetch_assembler
    import fetch_pkg::*;
#(
    parameter int byte_width = BYTE_W,
    parameter int width      = 4 * byte_width
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  rd,
    input  logic [CNT_W-1:0]      idx,
    input  logic [byte_width-1:0] data,
    output logic [width-1:0]      buffer
);

    logic             valid_d;
    logic [CNT_W-1:0] idx_d;

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_d <= 1'b0;
            idx_d   <= '0;
            buffer  <= '0;
        end else if (clear) begin
            // Dropping valid_d discards the byte returning in the clear cycle.
            valid_d <= 1'b0;
            idx_d   <= '0;
            buffer  <= '0;
        end else begin
            valid_d <= rd;
            idx_d   <= idx;
            if (valid_d) begin
                buffer[width - 1 - int'(idx_d) * byte_width -: byte_width] <= data;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads four bytes from a 1-cycle-latency byte memory,
// issues the assembled instruction to the decoder and waits for its ready.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    byte_width = BYTE_W,
    parameter int                    width      = 4 * byte_width,
    parameter int                    addr_width = 16,
    parameter logic [addr_width-1:0] reset_pc   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  redirect,
    input  logic [addr_width-1:0] redirect_pc,
    output logic [addr_width-1:0] mem_addr,
    output logic                  mem_rd,
    input  logic [byte_width-1:0] mem_data,
    output logic [width-1:0]      instruction_out,
    output logic                  start,
    output logic [addr_width-1:0] pc_out,
    input  logic                  dec_ready,
    output logic                  busy
);

    state_t                state, state_n;
    logic [addr_width-1:0] pc, pc_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic [addr_width-1:0] addr_q;
    logic [width-1:0]      instr_q;
    logic [addr_width-1:0] pc_out_q;
    logic [width-1:0]      buffer;

    fetch_assembler #(
        .byte_width(byte_width),
        .width     (width)
    ) u_assembler (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (redirect),
        .rd    (mem_rd),
        .idx   (cnt),
        .data  (mem_data),
        .buffer(buffer)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= reset_pc;
            cnt      <= '0;
            addr_q   <= '0;
            instr_q  <= '0;
            pc_out_q <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            cnt   <= cnt_n;
            if (mem_rd) addr_q <= mem_addr;
            if (start) begin
                instr_q  <= buffer;
                pc_out_q <= pc;
            end
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        cnt_n   = cnt;
        if (redirect) begin
            state_n = enable ? REQ : IDLE;
            pc_n    = redirect_pc;
            cnt_n   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (enable) begin
                        state_n = REQ;
                        cnt_n   = '0;
                    end
                end
                REQ: begin
                    cnt_n = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(REQ_BYTES - 1)) state_n = DRAIN;
                end
                DRAIN: state_n = ISSUE;
                ISSUE: begin
                    state_n = WAIT;
                    pc_n    = pc + addr_width'(REQ_BYTES);
                end
                WAIT: begin
                    if (dec_ready) begin
                        state_n = enable ? REQ : IDLE;
                        cnt_n   = '0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Outputs hold their last issued / last requested values between events.
    always_comb begin
        mem_rd          = (state == REQ) && !redirect;
        start           = (state == ISSUE) && !redirect;
        busy            = (state != IDLE);
        mem_addr        = mem_rd ? pc + addr_width'(cnt) : addr_q;
        instruction_out = start ? buffer : instr_q;
        pc_out          = start ? pc : pc_out_q;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: one instance fetching from address 0 and one
// reset to 16'hFFFE to cover address wrap.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int AW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, enable, redirect, dec_ready;
    logic [AW-1:0] redirect_pc, mem_addr, pc_out;
    logic          mem_rd, start, busy;
    logic [7:0]    mem_data;
    logic [31:0]   instruction_out;

    logic          w_enable, w_dec_ready, w_mem_rd, w_start, w_busy;
    logic [AW-1:0] w_mem_addr, w_pc_out;
    logic [7:0]    w_mem_data;
    logic [31:0]   w_instr;

    logic [7:0] mem [0:65535];
    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int last_start = 0;

    fetch_unit #(.reset_pc(16'h0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .mem_addr       (mem_addr),
        .mem_rd         (mem_rd),
        .mem_data       (mem_data),
        .instruction_out(instruction_out),
        .start          (start),
        .pc_out         (pc_out),
        .dec_ready      (dec_ready),
        .busy           (busy)
    );

    fetch_unit #(.reset_pc(16'hFFFE)) w_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (w_enable),
        .redirect       (1'b0),
        .redirect_pc    (16'h0000),
        .mem_addr       (w_mem_addr),
        .mem_rd         (w_mem_rd),
        .mem_data       (w_mem_data),
        .instruction_out(w_instr),
        .start          (w_start),
        .pc_out         (w_pc_out),
        .dec_ready      (w_dec_ready),
        .busy           (w_busy)
    );

    function automatic logic [7:0] wrap_mem(input logic [15:0] a);
        case (a)
            16'hFFFE: return 8'hAA;
            16'hFFFF: return 8'hBB;
            16'h0000: return 8'hCC;
            16'h0001: return 8'hDD;
            default:  return a[7:0];
        endcase
    endfunction

    // 1-cycle-latency memories; EE marks a cycle with no read outstanding.
    always @(posedge clk) mem_data   <= mem_rd ? mem[mem_addr] : 8'hEE;
    always @(posedge clk) w_mem_data <= w_mem_rd ? wrap_mem(w_mem_addr) : 8'hEE;
    always @(posedge clk) cycle      <= cycle + 1;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Caller has entered the first REQ cycle; checks four reads then DRAIN.
    task automatic req_phase(input logic [15:0] base, input string name);
        logic [15:0] exp_a;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) cyc();
            @(negedge clk);
            exp_a = base + 16'(k);
            checks++;
            if ({mem_rd, mem_addr, start} !== {1'b1, exp_a, 1'b0}) begin
                errors++;
                $display("FAIL %s_req%0d rd/addr/start got %b/%h/%b want 1/%h/0",
                         name, k, mem_rd, mem_addr, start, exp_a);
            end
        end
        cyc();
        @(negedge clk);
        checks++;
        if ({mem_rd, start, busy, mem_addr} !== {3'b001, exp_a}) begin
            errors++;
            $display("FAIL %s_drain rd/start/busy/addr got %b/%b/%b/%h want 0/0/1/%h",
                     name, mem_rd, start, busy, mem_addr, exp_a);
        end
    endtask

    task automatic issue_phase(input logic [31:0] instr, input logic [15:0] pc, input string name);
        cyc();
        @(negedge clk);
        last_start = cycle;
        checks++;
        if ({start, mem_rd, instruction_out, pc_out} !== {2'b10, instr, pc}) begin
            errors++;
            $display("FAIL %s_issue start/rd/instr/pc got %b/%b/%h/%h want 1/0/%h/%h",
                     name, start, mem_rd, instruction_out, pc_out, instr, pc);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; redirect = 1'b0; redirect_pc = '0; dec_ready = 1'b0;
        w_enable = 1'b0; w_dec_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, mem_rd, start} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl busy/rd/start got %b%b%b want 000", busy, mem_rd, start);
        end
        checks++;
        if ({mem_addr, instruction_out, pc_out} !== 64'h0) begin
            errors++;
            $display("FAIL reset_data addr/instr/pc got %h/%h/%h want 0/0/0",
                     mem_addr, instruction_out, pc_out);
        end
    endtask

    task automatic test_first_fetch();
        cyc(); rst_n = 1'b1; enable = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, mem_rd} !== 2'b00) begin
            errors++;
            $display("FAIL first_idle busy/rd got %b%b want 00", busy, mem_rd);
        end
        cyc();
        req_phase(16'h0000, "first");
        issue_phase(32'h11223344, 16'h0000, "first");
        for (int i = 0; i < 3; i++) begin
            cyc();
            @(negedge clk);
            checks++;
            if ({busy, mem_rd, start, instruction_out} !== {3'b100, 32'h11223344}) begin
                errors++;
                $display("FAIL first_wait%0d busy/rd/start/instr got %b%b%b/%h want 100/11223344",
                         i, busy, mem_rd, start, instruction_out);
            end
        end
        cyc(); dec_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_rd !== 1'b0) begin
            errors++;
            $display("FAIL first_ready_cycle rd got %b want 0", mem_rd);
        end
    endtask

    task automatic test_back_to_back();
        int t1;
        cyc();
        req_phase(16'h0004, "b2b_a");
        issue_phase(32'h55667788, 16'h0004, "b2b_a");
        t1 = last_start;
        cyc();
        @(negedge clk);
        checks++;
        if ({start, mem_rd} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_wait start/rd got %b%b want 00", start, mem_rd);
        end
        cyc();
        req_phase(16'h0008, "b2b_b");
        issue_phase(32'h999A9B9C, 16'h0008, "b2b_b");
        checks++;
        if (last_start - t1 !== 7) begin
            errors++;
            $display("FAIL b2b_interval got %0d want 7", last_start - t1);
        end
        cyc(); dec_ready = 1'b0;
    endtask

    task automatic test_redirect_req();
        cyc(); dec_ready = 1'b1;
        cyc(); dec_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (k > 0) cyc();
            @(negedge clk);
            checks++;
            if ({mem_rd, mem_addr} !== {1'b1, 16'h000C + 16'(k)}) begin
                errors++;
                $display("FAIL redir_req_pre%0d rd/addr got %b/%h want 1/%h",
                         k, mem_rd, mem_addr, 16'h000C + 16'(k));
            end
        end
        cyc(); redirect = 1'b1; redirect_pc = 16'h0100;
        @(negedge clk);
        checks++;
        if ({mem_rd, start} !== 2'b00) begin
            errors++;
            $display("FAIL redir_req_cycle rd/start got %b%b want 00", mem_rd, start);
        end
        cyc(); redirect = 1'b0;
        req_phase(16'h0100, "redir_req");
        issue_phase(32'hA1A2A3A4, 16'h0100, "redir_req");
    endtask

    task automatic test_redirect_issue();
        cyc(); dec_ready = 1'b1;
        cyc(); dec_ready = 1'b0;
        req_phase(16'h0104, "redir_iss_pre");
        cyc(); redirect = 1'b1; redirect_pc = 16'h0200;
        @(negedge clk);
        checks++;
        if ({start, mem_rd, instruction_out, pc_out} !== {2'b00, 32'hA1A2A3A4, 16'h0100}) begin
            errors++;
            $display("FAIL redir_iss_cycle start/rd/instr/pc got %b%b/%h/%h want 00/a1a2a3a4/0100",
                     start, mem_rd, instruction_out, pc_out);
        end
        cyc(); redirect = 1'b0;
        req_phase(16'h0200, "redir_iss");
        issue_phase(32'hC1C2C3C4, 16'h0200, "redir_iss");
    endtask

    task automatic test_pc_wrap();
        logic [15:0] exp_a;
        cyc(); w_enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            @(negedge clk);
            exp_a = 16'hFFFE + 16'(k);
            checks++;
            if ({w_mem_rd, w_mem_addr} !== {1'b1, exp_a}) begin
                errors++;
                $display("FAIL wrap_req%0d rd/addr got %b/%h want 1/%h", k, w_mem_rd, w_mem_addr, exp_a);
            end
        end
        cyc();
        cyc();
        @(negedge clk);
        checks++;
        if ({w_start, w_instr, w_pc_out} !== {1'b1, 32'hAABBCCDD, 16'hFFFE}) begin
            errors++;
            $display("FAIL wrap_issue start/instr/pc got %b/%h/%h want 1/aabbccdd/fffe",
                     w_start, w_instr, w_pc_out);
        end
        cyc(); w_dec_ready = 1'b1;
        cyc(); w_enable = 1'b0;
        @(negedge clk);
        checks++;
        if ({w_mem_rd, w_mem_addr} !== {1'b1, 16'h0002}) begin
            errors++;
            $display("FAIL wrap_next rd/addr got %b/%h want 1/0002", w_mem_rd, w_mem_addr);
        end
    endtask

    task automatic test_reset_mid_drain();
        cyc(); dec_ready = 1'b1;
        cyc(); dec_ready = 1'b0;
        req_phase(16'h0204, "rst_pre");
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, mem_rd, start, mem_addr, instruction_out, pc_out} !== 67'h0) begin
            errors++;
            $display("FAIL rst_async busy/rd/start/addr/instr/pc got %b%b%b/%h/%h/%h want 000/0/0/0",
                     busy, mem_rd, start, mem_addr, instruction_out, pc_out);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (start !== 1'b0) begin
                errors++;
                $display("FAIL rst_hold%0d start got %b want 0", i, start);
            end
        end
        cyc(); rst_n = 1'b1;
        cyc(); enable = 1'b0;
        req_phase(16'h0000, "restart");
        issue_phase(32'h11223344, 16'h0000, "restart");
        cyc(); dec_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL drop_wait busy got %b want 1", busy);
        end
        for (int i = 0; i < 2; i++) begin
            cyc();
            @(negedge clk);
            checks++;
            if ({busy, mem_rd} !== 2'b00) begin
                errors++;
                $display("FAIL drop_idle%0d busy/rd got %b%b want 00", i, busy, mem_rd);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'h3C;
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
        mem[4] = 8'h55; mem[5] = 8'h66; mem[6] = 8'h77; mem[7] = 8'h88;
        mem[8] = 8'h99; mem[9] = 8'h9A; mem[10] = 8'h9B; mem[11] = 8'h9C;
        mem[16'h0100] = 8'hA1; mem[16'h0101] = 8'hA2; mem[16'h0102] = 8'hA3; mem[16'h0103] = 8'hA4;
        mem[16'h0200] = 8'hC1; mem[16'h0201] = 8'hC2; mem[16'h0202] = 8'hC3; mem[16'h0203] = 8'hC4;

        test_reset();
        test_first_fetch();
        test_back_to_back();
        test_redirect_req();
        test_redirect_issue();
        test_pc_wrap();
        test_reset_mid_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cycle);
        $fatal(1, "watchdog");
    end

endmodule
